multiplier_multicycle_param: RTL and testbench

Parametrised iterative shift-add multiplier for the execute stage, generalising the fixed 64-bit radix-2 multicycle unit. It supports the RV64M multiply family (MUL, MULH, MULHSU, MULHU, MULW) with configurable width and bits retired per cycle. The pipeline stalls on `valid` until `done` is returned. A synchronous `flush` aborts an in-flight operation on a redirect.

---
 rtl/multiplier_multicycle_param_if.sv | 16 +
 rtl/multiplier_multicycle_param.sv | 86 ++++++++
 tb/tb_multiplier_multicycle_param.sv | 129 ++++++++++++
 3 files changed

// File: rtl/multiplier_multicycle_param_if.sv
// multiplier_multicycle_param_if: request/response bundle between the execute stage and the iterative multiplier.
interface multiplier_multicycle_param_if #(
    parameter int WIDTH = 64
);
    logic             valid_i;
    logic             flush_i;
    logic [1:0]       op_i;
    logic             word_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] c_o;
    modport master (output valid_i, flush_i, op_i, word_i, a_i, b_i, input busy_o, done_o, c_o);
    modport slave (input valid_i, flush_i, op_i, word_i, a_i, b_i, output busy_o, done_o, c_o);
endinterface

// File: rtl/multiplier_multicycle_param.sv
// multiplier_multicycle_param: iterative shift-add multiplier for the RV64M multiply family, STEP bits per cycle.
module multiplier_multicycle_param #(
    parameter int WIDTH = 64,
    parameter int STEP  = 1
) (
    input logic clk,
    input logic resetn,
    multiplier_multicycle_param_if.slave bus
);
    localparam int HW     = WIDTH / 2;
    localparam int ITER   = WIDTH / STEP;
    localparam int ITER_W = HW / STEP;
    localparam int CW     = $clog2(ITER + 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d, nxt, fin;
    logic [WIDTH-1:0]     mcand_q, mcand_d, c_q, c_d, a_mag, b_mag;
    logic [WIDTH+STEP-1:0] upper;
    logic [1:0]           op_q, op_d;
    logic                 word_q, word_d, neg_q, neg_d, a_neg, b_neg;
    // Upper half accumulates magnitudes; the multiplier drains out of the lower half as it shifts.
    always_comb begin
        a_neg   = ~bus.word_i & (bus.op_i == 2'b01 || bus.op_i == 2'b10) & bus.a_i[WIDTH-1];
        b_neg   = ~bus.word_i & (bus.op_i == 2'b01) & bus.b_i[WIDTH-1];
        a_mag   = bus.word_i ? {{HW{1'b0}}, bus.a_i[HW-1:0]} : a_neg ? -bus.a_i : bus.a_i;
        b_mag   = bus.word_i ? {{HW{1'b0}}, bus.b_i[HW-1:0]} : b_neg ? -bus.b_i : bus.b_i;
        upper   = {{STEP{1'b0}}, prod_q[2*WIDTH-1:WIDTH]}
                + {{STEP{1'b0}}, mcand_q} * {{WIDTH{1'b0}}, prod_q[STEP-1:0]};
        nxt     = {upper, prod_q[WIDTH-1:STEP]};
        fin     = neg_q ? -nxt : nxt;
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        mcand_d = mcand_q;
        c_d     = c_q;
        op_d    = op_q;
        word_d  = word_q;
        neg_d   = neg_q;
        if (bus.flush_i) begin
            state_d = IDLE;
        end else if (state_q == IDLE && bus.valid_i) begin
            state_d = BUSY;
            cnt_d   = bus.word_i ? CW'(ITER_W) : CW'(ITER);
            prod_d  = {{WIDTH{1'b0}}, b_mag};
            mcand_d = a_mag;
            op_d    = bus.op_i;
            word_d  = bus.word_i;
            neg_d   = a_neg ^ b_neg;
        end else if (state_q == BUSY) begin
            prod_d = nxt;
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d = DONE;
                c_d     = word_q ? {{HW{nxt[WIDTH-1]}}, nxt[WIDTH-1:HW]}
                        : op_q == 2'b00 ? fin[WIDTH-1:0] : fin[2*WIDTH-1:WIDTH];
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            c_q     <= '0;
            op_q    <= '0;
            word_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            c_q     <= c_d;
            op_q    <= op_d;
            word_q  <= word_d;
            neg_q   <= neg_d;
        end
    end
    assign bus.busy_o = state_q == BUSY;
    assign bus.done_o = state_q == DONE && !bus.flush_i;
    assign bus.c_o    = c_q;
endmodule

// File: tb/tb_multiplier_multicycle_param.sv
// tb_multiplier_multicycle_param: STEP=1 and STEP=4 instances driven in lockstep against a 128-bit arithmetic model.
module tb_multiplier_multicycle_param;
    logic clk = 1'b0;
    logic resetn = 1'b1;
    int errors = 0;
    int checks = 0;
    logic [63:0] last_c;
    multiplier_multicycle_param_if #(.WIDTH(64)) m1 ();
    multiplier_multicycle_param_if #(.WIDTH(64)) m4 ();
    multiplier_multicycle_param #(.WIDTH(64), .STEP(1)) dut1 (.clk(clk), .resetn(resetn), .bus(m1));
    multiplier_multicycle_param #(.WIDTH(64), .STEP(4)) dut4 (.clk(clk), .resetn(resetn), .bus(m4));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] x, y, p;
        if (w) begin
            p = {{96{a[31]}}, a[31:0]} * {{96{b[31]}}, b[31:0]};
            return {{32{p[31]}}, p[31:0]};
        end
        x = (op == 2'b01 || op == 2'b10) ? {{64{a[63]}}, a} : {64'b0, a};
        y = (op == 2'b01) ? {{64{b[63]}}, b} : {64'b0, b};
        p = x * y;
        return op == 2'b00 ? p[63:0] : p[127:64];
    endfunction

    task automatic drive(input logic v, input logic f, input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
        m1.valid_i = v; m1.flush_i = f; m1.op_i = op; m1.word_i = w; m1.a_i = a; m1.b_i = b;
        m4.valid_i = v; m4.flush_i = f; m4.op_i = op; m4.word_i = w; m4.a_i = a; m4.b_i = b;
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] exp;
        logic [63:0] c1 = 'x;
        logic [63:0] c4 = 'x;
        int d1 = 0, d4 = 0, bz1 = 0, bz4 = 0, ov = 0;
        int it = w ? 32 : 64;
        exp = model(op, w, a, b);
        drive(1'b1, 1'b0, op, w, a, b);
        @(posedge clk);
        #1 m1.valid_i = 1'b0; m4.valid_i = 1'b0;
        for (int k = 1; k <= 100 && (d1 == 0 || d4 == 0); k++) begin
            @(negedge clk);
            if (m1.busy_o) bz1++;
            if (m4.busy_o) bz4++;
            if ((m1.done_o && m1.busy_o) || (m4.done_o && m4.busy_o)) ov++;
            if (m1.done_o && d1 == 0) begin d1 = k; c1 = m1.c_o; end
            if (m4.done_o && d4 == 0) begin d4 = k; c4 = m4.c_o; end
        end
        chk({tag, "/lat_s1"}, 64'(d1), 64'(it + 1));
        chk({tag, "/lat_s4"}, 64'(d4), 64'(it / 4 + 1));
        chk({tag, "/busy_s1"}, 64'(bz1), 64'(it));
        chk({tag, "/busy_s4"}, 64'(bz4), 64'(it / 4));
        chk({tag, "/overlap"}, 64'(ov), 64'd0);
        chk({tag, "/c_s1"}, c1, exp);
        chk({tag, "/c_s4"}, c4, exp);
        @(posedge clk);
        #1;
        chk({tag, "/hold_s1"}, m1.c_o, exp);
        chk({tag, "/hold_s4"}, m4.c_o, exp);
        last_c = exp;
    endtask

    initial begin
        drive(1'b0, 1'b0, 2'b00, 1'b0, 64'd0, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst/busy", {62'd0, m1.busy_o, m4.busy_o}, 64'd0);
        chk("rst/done", {62'd0, m1.done_o, m4.done_o}, 64'd0);
        chk("rst/c_s1", m1.c_o, 64'd0);
        chk("rst/c_s4", m4.c_o, 64'd0);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        run("mul3x5", 2'b00, 1'b0, 64'd3, 64'd5);
        chk("mul3x5/const", last_c, 64'd15);
        run("mulhu_ones", 2'b11, 1'b0, '1, '1);
        run("mul_ones", 2'b00, 1'b0, '1, '1);
        run("mulh_min", 2'b01, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        run("mulh_ones", 2'b01, 1'b0, '1, '1);
        run("mulhsu_ones", 2'b10, 1'b0, '1, '1);
        run("mulw", 2'b01, 1'b0 | 1'b1, 64'h7FFF_FFFF, 64'd2);
        chk("mulw/const", last_c, 64'hFFFF_FFFF_FFFF_FFFE);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 64'd9, 64'd9);
        @(posedge clk);
        #1 m1.valid_i = 1'b0; m4.valid_i = 1'b0;
        repeat (9) @(posedge clk);
        #1 m1.flush_i = 1'b1; m4.flush_i = 1'b1;
        @(negedge clk);
        chk("flush/done", {62'd0, m1.done_o, m4.done_o}, 64'd0);
        chk("flush/busy", {62'd0, m1.busy_o, m4.busy_o}, 64'd3);
        @(posedge clk);
        #1 m1.flush_i = 1'b0; m4.flush_i = 1'b0;
        @(negedge clk);
        chk("flush/idle", {60'd0, m1.busy_o, m4.busy_o, m1.done_o, m4.done_o}, 64'd0);
        chk("flush/c_s1", m1.c_o, last_c);
        chk("flush/c_s4", m4.c_o, last_c);
        run("mul7x6", 2'b00, 1'b0, 64'd7, 64'd6);
        chk("mul7x6/const", last_c, 64'd42);
        for (int i = 0; i < 6; i++) begin
            run("rand", 2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
                {$urandom, $urandom}, {$urandom, $urandom});
        end
        drive(1'b1, 1'b0, 2'b00, 1'b0, 64'd3, 64'd5);
        @(posedge clk);
        #1 m1.valid_i = 1'b0; m4.valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        chk("areset/pre_busy", {62'd0, m1.busy_o, m4.busy_o}, 64'd3);
        resetn = 1'b1;
        #1;
        chk("areset/busy", {62'd0, m1.busy_o, m4.busy_o}, 64'd0);
        chk("areset/done", {62'd0, m1.done_o, m4.done_o}, 64'd0);
        chk("areset/c_s1", m1.c_o, 64'd0);
        chk("areset/c_s4", m4.c_o, 64'd0);
        @(posedge clk);
        #1 resetn = 1'b0;
        run("post_reset", 2'b11, 1'b0, 64'hDEAD_BEEF_0123_4567, 64'h0FED_CBA9_8765_4321);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
